// File: rtl/bird_motion_ctrl.sv
// Move-command source for the bird light column: synchronises the player key,
// generates the gravity tick and sequences the IDLE/PLAY/OVER game.
module bird_motion_ctrl #(
    parameter int FALL_PERIOD = 25_000_000,
    parameter int CNT_W       = $clog2(FALL_PERIOD)
) (
    input  logic clk,
    input  logic reset,
    input  logic key_raw,
    input  logic crash,
    output logic flap,
    output logic fall,
    output logic clear,
    output logic playing,
    output logic game_over
);

    // No valid/ready handshakes here: flap, fall and clear are single-cycle
    // strobes that the light column must consume on the cycle they are high.

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        OVER = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] TERM = CNT_W'(FALL_PERIOD - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             s1, s2, s3;
    logic             press;

    // Chain resets to 1 so a key already held at reset release is not a press.
    assign press = s2 & ~s3;

    always_ff @(posedge clk) begin
        if (reset) begin
            s1        <= 1'b1;
            s2        <= 1'b1;
            s3        <= 1'b1;
            state     <= IDLE;
            cnt       <= '0;
            flap      <= 1'b0;
            fall      <= 1'b0;
            clear     <= 1'b0;
            playing   <= 1'b0;
            game_over <= 1'b0;
        end else begin
            s1    <= key_raw;
            s2    <= s1;
            s3    <= s2;
            flap  <= 1'b0;
            fall  <= 1'b0;
            clear <= 1'b0;
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (press) begin
                        state   <= PLAY;
                        playing <= 1'b1;
                    end
                end
                PLAY: begin
                    // Crash outranks a press, and a press outranks the gravity tick.
                    if (crash) begin
                        state     <= OVER;
                        playing   <= 1'b0;
                        game_over <= 1'b1;
                        cnt       <= '0;
                    end else if (press) begin
                        flap <= 1'b1;
                        cnt  <= '0;
                    end else if (cnt == TERM) begin
                        fall <= 1'b1;
                        cnt  <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                OVER: begin
                    cnt <= '0;
                    if (press) begin
                        state     <= IDLE;
                        game_over <= 1'b0;
                        clear     <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    cnt       <= '0;
                    playing   <= 1'b0;
                    game_over <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bird_motion_ctrl.sv
// Bench for bird_motion_ctrl: directed game scenarios with fixed expected
// timelines, then random key/crash/reset traffic against a behavioural model.
module tb_bird_motion_ctrl;

    localparam int FP = 4;
    localparam int M_IDLE = 0;
    localparam int M_PLAY = 1;
    localparam int M_OVER = 2;

    logic clk = 1'b0;
    logic reset, key_raw, crash;
    logic flap, fall, clear, playing, game_over;

    int vectors = 0;
    int fails = 0;
    int cyc_n = 0;

    // Reference model: key history and game mode with cycles since last restart.
    logic [2:0] key_hist;
    int         m_mode;
    int         m_ticks;
    logic       e_flap, e_fall, e_clear, e_playing, e_over;

    bird_motion_ctrl #(.FALL_PERIOD(FP)) dut (
        .clk       (clk),
        .reset     (reset),
        .key_raw   (key_raw),
        .crash     (crash),
        .flap      (flap),
        .fall      (fall),
        .clear     (clear),
        .playing   (playing),
        .game_over (game_over)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s cycle %0d: observed %b expected %b", tag, cyc_n, obs, exp);
        end
    endtask

    // Press exists when the key was high two edges ago and low three edges ago.
    task automatic model_edge(input logic r, input logic k, input logic c);
        logic press;
        e_flap  = 1'b0;
        e_fall  = 1'b0;
        e_clear = 1'b0;
        if (r) begin
            key_hist = 3'b111;
            m_mode   = M_IDLE;
            m_ticks  = 0;
        end else begin
            press    = key_hist[1] & ~key_hist[2];
            key_hist = {key_hist[1:0], k};
            if (m_mode == M_IDLE) begin
                if (press) begin
                    m_mode  = M_PLAY;
                    m_ticks = 0;
                end
            end else if (m_mode == M_PLAY) begin
                if (c) begin
                    m_mode = M_OVER;
                end else if (press) begin
                    e_flap  = 1'b1;
                    m_ticks = 0;
                end else begin
                    m_ticks++;
                    if (m_ticks == FP) begin
                        e_fall  = 1'b1;
                        m_ticks = 0;
                    end
                end
            end else if (press) begin
                m_mode  = M_IDLE;
                e_clear = 1'b1;
            end
        end
        e_playing = (m_mode == M_PLAY);
        e_over    = (m_mode == M_OVER);
    endtask

    task automatic step(input logic r, input logic k, input logic c);
        reset   = r;
        key_raw = k;
        crash   = c;
        @(posedge clk);
        #1;
        cyc_n++;
        model_edge(r, k, c);
        chk("flap", flap, e_flap);
        chk("fall", fall, e_fall);
        chk("clear", clear, e_clear);
        chk("playing", playing, e_playing);
        chk("game_over", game_over, e_over);
        chk("flap_fall_excl", flap & fall, 1'b0);
    endtask

    initial begin
        logic k, c, r;
        logic key_seq;

        // 1: reset then a quiet idle period
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 1'b0, 1'b0);
            chk("idle_quiet", playing | game_over | flap | fall | clear, 1'b0);
        end

        // 2-5: one full game on a fixed timeline; i is the edge index after the first key rise
        for (int i = 0; i <= 44; i++) begin
            key_seq = (i <= 10) || (i >= 13 && i <= 23) || (i >= 25 && i <= 32)
                   || (i >= 35 && i <= 37) || (i >= 40);
            step(1'b0, key_seq, (i == 37) || (i == 39));
            chk("t_fall", fall, (i == 6) || (i == 10) || (i == 14) || (i == 19)
                             || (i == 23) || (i == 31) || (i == 35));
            chk("t_flap", flap, (i == 15) || (i == 27));
            chk("t_playing", playing, (i >= 2) && (i < 37));
            chk("t_game_over", game_over, (i >= 37) && (i < 42));
            chk("t_clear", clear, i == 42);
        end

        // 6: key held through reset release, then a real press, then reset mid-play
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 1'b1, 1'b0);
            chk("held_no_start", playing, 1'b0);
        end
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        chk("restart_playing", playing, 1'b1);
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        chk("mid_reset_playing", playing, 1'b0);
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b0, 1'b0);
            chk("post_reset_quiet", flap | fall | playing, 1'b0);
        end

        // Random traffic: key toggles occasionally, rare crash and reset
        k = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 3) == 0) k = ~k;
            c = ($urandom_range(0, 15) == 0);
            r = ($urandom_range(0, 199) == 0);
            step(r, k, c);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
